// File: rtl/ex_stage_params.sv
// rtl/ex_stage_params.sv - EX to IO bundle types
package ex_stage_params;

    typedef enum logic [2:0] {
        MEM_NONE  = 3'd0,
        MEM_BYTE  = 3'd1,
        MEM_HALF  = 3'd2,
        MEM_WORD  = 3'd3,
        MEM_LEFT  = 3'd4,
        MEM_RIGHT = 3'd5
    } MemoryIOType;

    // Live divider output; it is driven continuously by the divider in EX
    // and is not part of the registered payload.
    typedef struct packed {
        logic        result_valid;
        logic [31:0] quotient;
        logic [31:0] remainder;
    } DivideResult;

    typedef struct packed {
        logic [31:0] program_count;
        logic [31:0] alu_result;
        logic [63:0] multiply_result;
        logic [31:0] source_register_data;
        logic [31:0] multi_use_register_data;
        logic [1:0]  memory_address_final;
        MemoryIOType memory_io_type;
        logic        memory_io_unsigned;
        logic        result_is_from_memory;
        logic        result_high;
        logic        result_low;
        logic        multiply_valid;
        logic        divide_valid;
        logic        high_low_write;
        logic        high_low_select;
        logic [4:0]  destination_register;
        logic        register_write;
        logic        move_from_cp0;
        logic        cp0_write;
        logic [7:0]  cp0_address;
        logic        exception_valid;
        logic [4:0]  exception_code;
        logic        in_delay_slot;
        logic        eret;
    } EXToIOPayload;

    typedef struct packed {
        logic         valid;
        DivideResult  divide;
        EXToIOPayload payload;
    } EXToIOData;

endpackage

// File: rtl/io_stage_params.sv
// rtl/io_stage_params.sv - IO stage output bundle types
package io_stage_params;

    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic [31:0] final_result;
        logic [4:0]  destination_register;
        logic        register_write;
        logic        move_from_cp0;
        logic        cp0_write;
        logic [7:0]  cp0_address;
        logic        exception_valid;
        logic [4:0]  exception_code;
        logic        in_delay_slot;
        logic        eret;
    } IOToWBData;

    typedef struct packed {
        logic        valid;
        logic        data_valid;
        logic [4:0]  write_register;
        logic [31:0] write_data;
    } IOToIDBackPassData;

endpackage

// File: rtl/wb_stage_params.sv
// rtl/wb_stage_params.sv - WB flush bundle types
package wb_stage_params;

    typedef struct packed {
        logic exception_valid;
        logic eret_flush;
    } WBExceptionBus;

endpackage

// File: rtl/io_stage.sv
// rtl/io_stage.sv - memory-access stage: load alignment, HI/LO, divide stall
module io_stage
    import ex_stage_params::*;
    import wb_stage_params::*;
    import io_stage_params::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_allow_in,
    output logic              io_allow_in,
    input  EXToIOData         ex_to_io_bus,
    input  logic [31:0]       data_ram_read_data,
    input  WBExceptionBus     wb_exception_bus,
    output IOToWBData         io_to_wb_bus,
    output IOToIDBackPassData io_to_id_back_pass_bus
);

    EXToIOPayload from_ex;
    logic         io_valid;
    logic         divide_done;
    logic [31:0]  quotient_held;
    logic [31:0]  remainder_held;
    logic [31:0]  hi;
    logic [31:0]  lo;

    logic         flush;
    logic         io_ready_go;
    logic         io_leave;
    logic         hilo_commit;
    logic [31:0]  quotient;
    logic [31:0]  remainder;
    logic [7:0]   load_byte;
    logic [15:0]  load_half;
    logic         byte_sign;
    logic         half_sign;
    logic [31:0]  load_value;
    logic [31:0]  final_result;

    assign flush       = wb_exception_bus.exception_valid | wb_exception_bus.eret_flush;
    assign io_ready_go = !(from_ex.divide_valid && !divide_done && !ex_to_io_bus.divide.result_valid);
    assign io_allow_in = !io_valid || (io_ready_go && wb_allow_in);
    assign io_leave    = io_valid && io_ready_go && wb_allow_in;
    assign hilo_commit = io_leave && !from_ex.exception_valid && !flush;

    // The divider may report on the same cycle the instruction leaves, so use the live value until latched
    assign quotient  = divide_done ? quotient_held  : ex_to_io_bus.divide.quotient;
    assign remainder = divide_done ? remainder_held : ex_to_io_bus.divide.remainder;

    // Occupancy of the stage; a flush drops whatever is held or arriving
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_valid <= 1'b0;
        end else if (flush) begin
            io_valid <= 1'b0;
        end else if (io_allow_in) begin
            io_valid <= ex_to_io_bus.valid;
        end
    end

    // Payload capture, intentionally without reset
    always_ff @(posedge clock) begin
        if (ex_to_io_bus.valid && io_allow_in) begin
            from_ex <= ex_to_io_bus.payload;
        end
    end

    // Remember that the held divide has its result, cleared when it leaves or is flushed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            divide_done <= 1'b0;
        end else if (flush || io_leave) begin
            divide_done <= 1'b0;
        end else if (io_valid && from_ex.divide_valid && !divide_done && ex_to_io_bus.divide.result_valid) begin
            divide_done <= 1'b1;
        end
    end

    // Latch the divider result on its pulse so the stall can release later
    always_ff @(posedge clock) begin
        if (io_valid && from_ex.divide_valid && !divide_done && ex_to_io_bus.divide.result_valid) begin
            quotient_held  <= ex_to_io_bus.divide.quotient;
            remainder_held <= ex_to_io_bus.divide.remainder;
        end
    end

    // HI/LO update as the instruction hands off to WB
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (hilo_commit) begin
            if (from_ex.multiply_valid) begin
                hi <= from_ex.multiply_result[63:32];
                lo <= from_ex.multiply_result[31:0];
            end else if (from_ex.divide_valid) begin
                hi <= remainder;
                lo <= quotient;
            end else if (from_ex.high_low_write) begin
                if (from_ex.high_low_select) begin
                    hi <= from_ex.source_register_data;
                end else begin
                    lo <= from_ex.source_register_data;
                end
            end
        end
    end

    // Load data alignment and merge with rt for LWL/LWR
    always_comb begin
        load_byte  = data_ram_read_data[7:0];
        load_half  = data_ram_read_data[15:0];
        load_value = data_ram_read_data;
        case (from_ex.memory_address_final)
            2'd0:    load_byte = data_ram_read_data[7:0];
            2'd1:    load_byte = data_ram_read_data[15:8];
            2'd2:    load_byte = data_ram_read_data[23:16];
            default: load_byte = data_ram_read_data[31:24];
        endcase
        if (from_ex.memory_address_final[1]) begin
            load_half = data_ram_read_data[31:16];
        end
        byte_sign = !from_ex.memory_io_unsigned && load_byte[7];
        half_sign = !from_ex.memory_io_unsigned && load_half[15];
        case (from_ex.memory_io_type)
            MEM_BYTE: load_value = {{24{byte_sign}}, load_byte};
            MEM_HALF: load_value = {{16{half_sign}}, load_half};
            MEM_LEFT: begin
                case (from_ex.memory_address_final)
                    2'd0:    load_value = {data_ram_read_data[7:0],  from_ex.multi_use_register_data[23:0]};
                    2'd1:    load_value = {data_ram_read_data[15:0], from_ex.multi_use_register_data[15:0]};
                    2'd2:    load_value = {data_ram_read_data[23:0], from_ex.multi_use_register_data[7:0]};
                    default: load_value = data_ram_read_data;
                endcase
            end
            MEM_RIGHT: begin
                case (from_ex.memory_address_final)
                    2'd0:    load_value = data_ram_read_data;
                    2'd1:    load_value = {from_ex.multi_use_register_data[31:24], data_ram_read_data[31:8]};
                    2'd2:    load_value = {from_ex.multi_use_register_data[31:16], data_ram_read_data[31:16]};
                    default: load_value = {from_ex.multi_use_register_data[31:8],  data_ram_read_data[31:24]};
                endcase
            end
            default: load_value = data_ram_read_data;
        endcase
    end

    // Result selection: memory, then HI, then LO, then ALU
    always_comb begin
        final_result = from_ex.alu_result;
        if (from_ex.result_is_from_memory) begin
            final_result = load_value;
        end else if (from_ex.result_high) begin
            final_result = hi;
        end else if (from_ex.result_low) begin
            final_result = lo;
        end
    end

    // Output bundles towards WB and the ID forwarding path
    always_comb begin
        io_to_wb_bus.valid                = io_valid && io_ready_go;
        io_to_wb_bus.program_count        = from_ex.program_count;
        io_to_wb_bus.final_result         = final_result;
        io_to_wb_bus.destination_register = from_ex.destination_register;
        io_to_wb_bus.register_write       = from_ex.register_write;
        io_to_wb_bus.move_from_cp0        = from_ex.move_from_cp0;
        io_to_wb_bus.cp0_write            = from_ex.cp0_write;
        io_to_wb_bus.cp0_address          = from_ex.cp0_address;
        io_to_wb_bus.exception_valid      = from_ex.exception_valid;
        io_to_wb_bus.exception_code       = from_ex.exception_code;
        io_to_wb_bus.in_delay_slot        = from_ex.in_delay_slot;
        io_to_wb_bus.eret                 = from_ex.eret;

        io_to_id_back_pass_bus.valid          = io_valid && from_ex.register_write;
        io_to_id_back_pass_bus.data_valid     = io_valid && from_ex.register_write && io_ready_go && !from_ex.move_from_cp0;
        io_to_id_back_pass_bus.write_register = from_ex.destination_register;
        io_to_id_back_pass_bus.write_data     = final_result;
    end

endmodule

// File: tb/tb_io_stage.sv
// tb/tb_io_stage.sv - randomized model-checked bench for io_stage
module tb_io_stage;
    import ex_stage_params::*;
    import wb_stage_params::*;
    import io_stage_params::*;

    logic              clock;
    logic              reset_n;
    logic              wb_allow_in;
    logic              io_allow_in;
    EXToIOData         ex_to_io_bus;
    logic [31:0]       data_ram_read_data;
    WBExceptionBus     wb_exception_bus;
    IOToWBData         io_to_wb_bus;
    IOToIDBackPassData io_to_id_back_pass_bus;

    int vectors;
    int miscompares;

    io_stage dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .wb_allow_in            (wb_allow_in),
        .io_allow_in            (io_allow_in),
        .ex_to_io_bus           (ex_to_io_bus),
        .data_ram_read_data     (data_ram_read_data),
        .wb_exception_bus       (wb_exception_bus),
        .io_to_wb_bus           (io_to_wb_bus),
        .io_to_id_back_pass_bus (io_to_id_back_pass_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: sign/zero extension and LWL/LWR merges written as shifts and masks
    function automatic logic [31:0] model_load(input EXToIOPayload p, input logic [31:0] rd);
        int unsigned a;
        int unsigned sh;
        logic [31:0] v;
        a = p.memory_address_final;
        case (p.memory_io_type)
            MEM_BYTE: begin
                v = (rd >> (8 * a)) & 32'hFF;
                if (!p.memory_io_unsigned && v[7]) v = v - 32'd256;
            end
            MEM_HALF: begin
                v = (rd >> (16 * (a / 2))) & 32'hFFFF;
                if (!p.memory_io_unsigned && v[15]) v = v - 32'd65536;
            end
            MEM_LEFT: begin
                sh = 8 * (3 - a);
                v = (rd << sh) | (p.multi_use_register_data & ((32'd1 << sh) - 32'd1));
            end
            MEM_RIGHT: begin
                sh = 8 * a;
                v = (rd >> sh) | (p.multi_use_register_data & ~(32'hFFFF_FFFF >> sh));
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Model state: what instruction sits in the stage and the architectural HI/LO
    logic         m_valid;
    EXToIOPayload m_occ;
    logic [31:0]  m_hi, m_lo, m_q, m_r;
    logic         m_div_seen;
    logic         m_waiting, m_leave, m_flush, m_allow;
    logic [31:0]  m_final;

    // Compare DUT outputs with the model mid-cycle, then advance the model to the next edge
    always @(negedge clock) begin
        if (!reset_n) begin
            m_valid    = 1'b0;
            m_hi       = 32'd0;
            m_lo       = 32'd0;
            m_div_seen = 1'b0;
        end else begin
            m_waiting = m_valid && m_occ.divide_valid && !m_div_seen && !ex_to_io_bus.divide.result_valid;
            m_allow   = !m_valid || (!m_waiting && wb_allow_in);
            m_flush   = wb_exception_bus.exception_valid || wb_exception_bus.eret_flush;
            m_leave   = m_valid && !m_waiting && wb_allow_in;
            if (m_valid && m_occ.result_is_from_memory) m_final = model_load(m_occ, data_ram_read_data);
            else if (m_valid && m_occ.result_high)      m_final = m_hi;
            else if (m_valid && m_occ.result_low)       m_final = m_lo;
            else                                        m_final = m_occ.alu_result;

            check("allow_in", 64'(io_allow_in), 64'(m_allow));
            check("wb_valid", 64'(io_to_wb_bus.valid), 64'(m_valid && !m_waiting));
            check("bp_valid", 64'(io_to_id_back_pass_bus.valid), 64'(m_valid && m_occ.register_write));
            check("bp_data_valid", 64'(io_to_id_back_pass_bus.data_valid),
                  64'(m_valid && m_occ.register_write && !m_waiting && !m_occ.move_from_cp0));
            if (m_valid) begin
                check("final_result", 64'(io_to_wb_bus.final_result), 64'(m_final));
                check("pc", 64'(io_to_wb_bus.program_count), 64'(m_occ.program_count));
                check("sideband",
                      64'({io_to_wb_bus.destination_register, io_to_wb_bus.register_write, io_to_wb_bus.move_from_cp0,
                           io_to_wb_bus.cp0_write, io_to_wb_bus.cp0_address, io_to_wb_bus.exception_valid,
                           io_to_wb_bus.exception_code, io_to_wb_bus.in_delay_slot, io_to_wb_bus.eret}),
                      64'({m_occ.destination_register, m_occ.register_write, m_occ.move_from_cp0,
                           m_occ.cp0_write, m_occ.cp0_address, m_occ.exception_valid,
                           m_occ.exception_code, m_occ.in_delay_slot, m_occ.eret}));
                if (m_occ.register_write) begin
                    check("bp_data", 64'({io_to_id_back_pass_bus.write_register, io_to_id_back_pass_bus.write_data}),
                          64'({m_occ.destination_register, m_final}));
                end
            end

            if (m_leave && !m_occ.exception_valid && !m_flush) begin
                if (m_occ.multiply_valid) begin
                    m_hi = m_occ.multiply_result[63:32];
                    m_lo = m_occ.multiply_result[31:0];
                end else if (m_occ.divide_valid) begin
                    m_lo = m_div_seen ? m_q : ex_to_io_bus.divide.quotient;
                    m_hi = m_div_seen ? m_r : ex_to_io_bus.divide.remainder;
                end else if (m_occ.high_low_write) begin
                    if (m_occ.high_low_select) m_hi = m_occ.source_register_data;
                    else                       m_lo = m_occ.source_register_data;
                end
            end
            if (m_flush || m_leave) begin
                m_div_seen = 1'b0;
            end else if (m_valid && m_occ.divide_valid && !m_div_seen && ex_to_io_bus.divide.result_valid) begin
                m_div_seen = 1'b1;
                m_q = ex_to_io_bus.divide.quotient;
                m_r = ex_to_io_bus.divide.remainder;
            end
            if (m_flush) begin
                m_valid = 1'b0;
            end else if (m_allow) begin
                m_valid = ex_to_io_bus.valid;
                if (ex_to_io_bus.valid) m_occ = ex_to_io_bus.payload;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input EXToIOPayload p);
        ex_to_io_bus.valid   = 1'b1;
        ex_to_io_bus.payload = p;
    endtask

    task automatic idle();
        ex_to_io_bus.valid = 1'b0;
    endtask

    function automatic EXToIOPayload rand_payload();
        EXToIOPayload p;
        int kind;
        p = '0;
        kind = $urandom_range(0, 7);
        p.program_count           = $urandom;
        p.alu_result              = $urandom;
        p.multiply_result         = {$urandom, $urandom};
        p.source_register_data    = $urandom;
        p.multi_use_register_data = $urandom;
        p.memory_address_final    = 2'($urandom_range(0, 3));
        p.destination_register    = 5'($urandom_range(0, 31));
        p.register_write          = 1'($urandom_range(0, 1));
        p.move_from_cp0           = ($urandom_range(0, 7) == 0);
        p.cp0_write               = ($urandom_range(0, 7) == 0);
        p.cp0_address             = 8'($urandom_range(0, 255));
        p.exception_valid         = ($urandom_range(0, 9) == 0);
        p.exception_code          = 5'($urandom_range(0, 31));
        p.in_delay_slot           = 1'($urandom_range(0, 1));
        p.eret                    = ($urandom_range(0, 15) == 0);
        case (kind)
            1: begin
                p.result_is_from_memory = 1'b1;
                p.memory_io_type        = MemoryIOType'(3'($urandom_range(1, 5)));
                p.memory_io_unsigned    = 1'($urandom_range(0, 1));
            end
            2: p.multiply_valid = 1'b1;
            3: p.divide_valid   = 1'b1;
            4: begin
                p.high_low_write  = 1'b1;
                p.high_low_select = 1'($urandom_range(0, 1));
            end
            5: p.result_high = 1'b1;
            6: p.result_low  = 1'b1;
            default: ;
        endcase
        return p;
    endfunction

    EXToIOPayload p;

    initial begin
        vectors            = 0;
        miscompares        = 0;
        reset_n            = 1'b0;
        wb_allow_in        = 1'b1;
        ex_to_io_bus       = '0;
        data_ram_read_data = 32'd0;
        wb_exception_bus   = '0;
        tick();
        tick();
        check("reset_allow_in", 64'(io_allow_in), 64'd1);
        check("reset_wb_valid", 64'(io_to_wb_bus.valid), 64'd0);
        check("reset_bp_valid", 64'({io_to_id_back_pass_bus.valid, io_to_id_back_pass_bus.data_valid}), 64'd0);
        reset_n = 1'b1;
        tick();

        // Byte/half loads
        data_ram_read_data = 32'h80FF_1234;
        p = '0;
        p.result_is_from_memory = 1'b1;
        p.register_write        = 1'b1;
        p.destination_register  = 5'd3;
        p.memory_io_type        = MEM_BYTE;
        p.memory_address_final  = 2'd3;
        drive(p);
        tick();
        p.memory_io_unsigned = 1'b1;
        drive(p);
        #1 check("lb", 64'(io_to_wb_bus.final_result), 64'hFFFF_FF80);
        tick();
        p.memory_io_unsigned   = 1'b0;
        p.memory_io_type       = MEM_HALF;
        p.memory_address_final = 2'd2;
        drive(p);
        #1 check("lbu", 64'(io_to_wb_bus.final_result), 64'h0000_0080);
        tick();
        idle();
        #1 check("lh", 64'(io_to_wb_bus.final_result), 64'hFFFF_80FF);
        tick();

        // Unaligned word merges
        data_ram_read_data        = 32'hAABB_CCDD;
        p.multi_use_register_data = 32'h1122_3344;
        p.memory_io_type          = MEM_LEFT;
        p.memory_address_final    = 2'd1;
        drive(p);
        tick();
        p.memory_io_type       = MEM_RIGHT;
        p.memory_address_final = 2'd2;
        drive(p);
        #1 check("lwl", 64'(io_to_wb_bus.final_result), 64'hCCDD_3344);
        tick();
        idle();
        #1 check("lwr", 64'(io_to_wb_bus.final_result), 64'h1122_AABB);
        tick();

        // MULT then MFHI, MFLO back to back
        p = '0;
        p.multiply_valid  = 1'b1;
        p.multiply_result = 64'h0000_0001_FFFF_FFFE;
        drive(p);
        tick();
        p = '0;
        p.result_high    = 1'b1;
        p.register_write = 1'b1;
        drive(p);
        tick();
        p.result_high = 1'b0;
        p.result_low  = 1'b1;
        drive(p);
        #1 check("mfhi_after_mult", 64'(io_to_wb_bus.final_result), 64'h1);
        tick();
        idle();
        #1 check("mflo_after_mult", 64'(io_to_wb_bus.final_result), 64'hFFFF_FFFE);
        tick();

        // Divide stall for 10 cycles, then result
        p = '0;
        p.divide_valid = 1'b1;
        drive(p);
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            #1 check("div_stall", 64'({io_allow_in, io_to_wb_bus.valid}), 64'd0);
            tick();
        end
        ex_to_io_bus.divide = {1'b1, 32'h0000_1234, 32'h0000_0056};
        #1 check("div_release", 64'({io_allow_in, io_to_wb_bus.valid}), 64'b11);
        tick();
        ex_to_io_bus.divide = '0;
        p = '0;
        p.result_low     = 1'b1;
        p.register_write = 1'b1;
        drive(p);
        tick();
        p.result_low  = 1'b0;
        p.result_high = 1'b1;
        drive(p);
        #1 check("div_quotient", 64'(io_to_wb_bus.final_result), 64'h1234);
        tick();
        idle();
        #1 check("div_remainder", 64'(io_to_wb_bus.final_result), 64'h56);
        tick();

        // WB back-pressure holds the ALU result steady
        wb_allow_in = 1'b0;
        p = '0;
        p.alu_result           = 32'hCAFE_F00D;
        p.program_count        = 32'h0000_0100;
        p.register_write       = 1'b1;
        p.destination_register = 5'd7;
        drive(p);
        tick();
        p.alu_result    = 32'h0BAD_0BAD;
        p.program_count = 32'h0000_0104;
        drive(p);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_allow_in", 64'(io_allow_in), 64'd0);
            check("hold_result", 64'({io_to_wb_bus.program_count, io_to_wb_bus.final_result}), 64'h0000_0100_CAFE_F00D);
            check("hold_bp_data_valid", 64'(io_to_id_back_pass_bus.data_valid), 64'd1);
            tick();
        end
        wb_allow_in = 1'b1;
        idle();
        tick();
        tick();

        // Flush drops a held MTHI without writing HI
        wb_allow_in = 1'b0;
        p = '0;
        p.high_low_write       = 1'b1;
        p.high_low_select      = 1'b1;
        p.source_register_data = 32'h5;
        drive(p);
        tick();
        idle();
        tick();
        wb_allow_in = 1'b1;
        wb_exception_bus.exception_valid = 1'b1;
        tick();
        wb_exception_bus.exception_valid = 1'b0;
        #1 check("flush_drop", 64'({io_allow_in, io_to_wb_bus.valid}), 64'b10);
        p = '0;
        p.result_high = 1'b1;
        drive(p);
        tick();
        idle();
        #1 check("flush_hi_kept", 64'(io_to_wb_bus.final_result), 64'h56);
        tick();

        // Asynchronous reset in the middle of a divide stall
        p = '0;
        p.divide_valid = 1'b1;
        drive(p);
        tick();
        idle();
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1 check("async_reset", 64'({io_allow_in, io_to_wb_bus.valid, io_to_id_back_pass_bus.valid}), 64'b100);
        tick();
        reset_n = 1'b1;
        p = '0;
        p.result_high = 1'b1;
        drive(p);
        tick();
        p.result_high = 1'b0;
        p.result_low  = 1'b1;
        drive(p);
        #1 check("reset_hi", 64'(io_to_wb_bus.final_result), 64'h0);
        tick();
        idle();
        #1 check("reset_lo", 64'(io_to_wb_bus.final_result), 64'h0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ex_to_io_bus.valid               = ($urandom_range(0, 9) < 7);
            ex_to_io_bus.payload             = rand_payload();
            ex_to_io_bus.divide.result_valid = ($urandom_range(0, 6) == 0);
            ex_to_io_bus.divide.quotient     = $urandom;
            ex_to_io_bus.divide.remainder    = $urandom;
            data_ram_read_data               = $urandom;
            wb_allow_in                      = ($urandom_range(0, 3) != 0);
            wb_exception_bus.exception_valid = ($urandom_range(0, 39) == 0);
            wb_exception_bus.eret_flush      = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();
        wb_exception_bus = '0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
